// File: rtl/eth_tx_packer_if.sv
// Byte-stream, TX-buffer write port and driver handshake for the Ethernet TX packer.
// slave: packer side. master: environment side (UART receiver, buffer RAM, W5300 driver).
interface eth_tx_packer_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  buf_wren;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic [15:0]           buf_wdata;
  logic                  eth_tx_req;
  logic [ADDR_WIDTH+1:0] eth_tx_len;
  logic                  eth_tx_done;
  logic                  overflow;

  modport slave (
    input  byte_valid, byte_data, eth_tx_done,
    output buf_wren, buf_waddr, buf_wdata, eth_tx_req, eth_tx_len, overflow
  );

  modport master (
    output byte_valid, byte_data, eth_tx_done,
    input  buf_wren, buf_waddr, buf_wdata, eth_tx_req, eth_tx_len, overflow
  );
endinterface

// File: rtl/eth_tx_packer.sv
// Packs a byte stream big-endian into 16-bit TX buffer words and requests transmission
// when the buffer is full or the stream has been idle; holds off until the driver is done.
module eth_tx_packer #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned IDLE_CYCLES = 100000
) (
  input logic            clk,
  input logic            rst_n,
  eth_tx_packer_if.slave io_bus
);

  localparam int unsigned CW = ADDR_WIDTH + 2;
  localparam int unsigned TW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] FullCount = {1'b1, {(ADDR_WIDTH + 1){1'b0}}};
  localparam logic [TW-1:0] Timeout   = TW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPad, StReq} state_e;

  state_e                r_state;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [TW-1:0]         r_timer;
  logic [7:0]            r_high;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [15:0]           r_wdata;
  logic                  r_req;
  logic [CW-1:0]         r_len;
  logic                  r_overflow;

  logic       w_valid;
  logic [7:0] w_data;
  logic       w_done;

  assign w_valid = io_bus.byte_valid;
  assign w_data  = io_bus.byte_data;
  assign w_done  = io_bus.eth_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_widx     <= '0;
      r_timer    <= '0;
      r_high     <= '0;
      r_wren     <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_req      <= 1'b0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_high  <= w_data;
            r_count <= CW'(1);
            r_timer <= '0;
            r_state <= StFill;
          end
        end
        StFill: begin
          // A full buffer flushes one cycle after its last word is written.
          if (r_count == FullCount) begin
            r_state <= StReq;
            r_req   <= 1'b1;
            r_len   <= r_count;
            if (w_valid) r_overflow <= 1'b1;
          end else if (w_valid) begin
            r_count <= r_count + 1'b1;
            r_timer <= '0;
            if (r_count[0]) begin
              r_wren  <= 1'b1;
              r_waddr <= r_widx;
              r_wdata <= {r_high, w_data};
              r_widx  <= r_widx + 1'b1;
            end else begin
              r_high <= w_data;
            end
          end else if (r_timer == Timeout) begin
            r_len <= r_count;
            if (r_count[0]) begin
              // Odd tail: pad the low half with zero before requesting.
              r_wren  <= 1'b1;
              r_waddr <= r_widx;
              r_wdata <= {r_high, 8'h00};
              r_state <= StPad;
            end else begin
              r_state <= StReq;
              r_req   <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StPad: begin
          if (w_valid) r_overflow <= 1'b1;
          r_state <= StReq;
          r_req   <= 1'b1;
        end
        StReq: begin
          if (w_valid) r_overflow <= 1'b1;
          if (w_done) begin
            r_req   <= 1'b0;
            r_len   <= '0;
            r_count <= '0;
            r_widx  <= '0;
            r_timer <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.buf_wren   = r_wren;
  assign io_bus.buf_waddr  = r_waddr;
  assign io_bus.buf_wdata  = r_wdata;
  assign io_bus.eth_tx_req = r_req;
  assign io_bus.eth_tx_len = r_len;
  assign io_bus.overflow   = r_overflow;

endmodule

// File: tb/tb_eth_tx_packer.sv
// Self-checking bench for eth_tx_packer: directed scenarios plus random packets,
// with expected words, lengths and flush timing derived from a byte-queue model.
module tb_eth_tx_packer;

  localparam int unsigned AW   = 9;
  localparam int unsigned IDLE = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  eth_tx_packer_if #(.ADDR_WIDTH(AW)) bus ();

  eth_tx_packer #(
    .ADDR_WIDTH (AW),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Write log captured by a monitor away from the active edge.
  logic [AW-1:0] wr_addr [4096];
  logic [15:0]   wr_data [4096];
  int            wr_total = 0;

  always @(negedge clk) begin
    if (bus.buf_wren === 1'b1 && wr_total < 4096) begin
      wr_addr[wr_total] <= bus.buf_waddr;
      wr_data[wr_total] <= bus.buf_wdata;
      wr_total          <= wr_total + 1;
    end
  end

  logic [7:0] pkt[$];
  int         base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_packet();
    pkt.delete();
    base = wr_total;
  endtask

  // accept=1: model expects the byte to enter the packet.
  task automatic send_byte(input logic [7:0] b, input bit accept);
    int n;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    if (accept) begin
      pkt.push_back(b);
      n = pkt.size();
      if (n % 2 == 0) begin
        check("wr_en", 32'(bus.buf_wren), 32'd1);
        check("wr_addr", 32'(bus.buf_waddr), 32'(n / 2 - 1));
        check("wr_data", 32'(bus.buf_wdata), {16'h0, pkt[n-2], pkt[n-1]});
      end else begin
        check("no_wr_odd", 32'(bus.buf_wren), 32'd0);
      end
    end else begin
      check("no_wr_drop", 32'(bus.buf_wren), 32'd0);
    end
  endtask

  task automatic wait_flush(input string tag, input int min_w, input int max_w);
    int waited = 0;
    int nw;
    logic [15:0] exp_w;
    while (bus.eth_tx_req !== 1'b1 && waited < 3000) begin
      tick();
      waited++;
    end
    check({tag, "_req"}, 32'(bus.eth_tx_req), 32'd1);
    check({tag, "_wait"}, 32'(waited >= min_w && waited <= max_w), 32'd1);
    check({tag, "_len"}, 32'(bus.eth_tx_len), 32'(pkt.size()));
    nw = (pkt.size() + 1) / 2;
    check({tag, "_nwr"}, 32'(wr_total - base), 32'(nw));
    for (int k = 0; k < nw && base + k < wr_total; k++) begin
      exp_w = {pkt[2*k], (2 * k + 1 < pkt.size()) ? pkt[2*k+1] : 8'h00};
      check({tag, "_waddr"}, 32'(wr_addr[base+k]), 32'(k));
      check({tag, "_wdata"}, 32'(wr_data[base+k]), 32'(exp_w));
    end
  endtask

  // drops: bytes sent while REQ is pending; with_byte: a byte rides along with the done pulse.
  task automatic release_req(input string tag, input int drops, input bit with_byte);
    int nw;
    nw = (pkt.size() + 1) / 2;
    for (int i = 0; i < drops; i++) send_byte(8'($urandom), 1'b0);
    check({tag, "_req_hold"}, 32'(bus.eth_tx_req), 32'd1);
    bus.eth_tx_done = 1'b1;
    if (with_byte) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
    end
    tick();
    bus.eth_tx_done = 1'b0;
    bus.byte_valid  = 1'b0;
    check({tag, "_req_low"}, 32'(bus.eth_tx_req), 32'd0);
    tick();
    check({tag, "_no_wr_req"}, 32'(wr_total - base), 32'(nw));
  endtask

  initial begin
    int n;
    bus.byte_valid  = 1'b0;
    bus.byte_data   = 8'h00;
    bus.eth_tx_done = 1'b0;
    idle(2);
    check("rst_wren", 32'(bus.buf_wren), 32'd0);
    check("rst_waddr", 32'(bus.buf_waddr), 32'd0);
    check("rst_wdata", 32'(bus.buf_wdata), 32'd0);
    check("rst_req", 32'(bus.eth_tx_req), 32'd0);
    check("rst_len", 32'(bus.eth_tx_len), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Even packet, idle flush.
    start_packet();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    wait_flush("even", IDLE, IDLE);
    release_req("even", 0, 1'b0);
    check("ovf_clean", 32'(bus.overflow), 32'd0);

    // Odd packet, padded tail.
    start_packet();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    wait_flush("odd", IDLE, IDLE + 1);
    release_req("odd", 0, 1'b0);

    // Full buffer, no timeout needed.
    start_packet();
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
    check("full_last_addr", 32'(bus.buf_waddr), 32'd511);
    check("full_last_data", 32'(bus.buf_wdata), 32'hFEFF);
    wait_flush("full", 1, 2);
    release_req("full", 0, 1'b0);

    // Drops while requesting; one rides with the done pulse.
    start_packet();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_flush("drop", IDLE, IDLE);
    release_req("drop", 5, 1'b1);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    start_packet();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    wait_flush("after_drop", IDLE, IDLE + 1);
    release_req("after_drop", 0, 1'b0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Byte landing on the timeout-expiry cycle restarts the timer.
    start_packet();
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(IDLE - 1);
    check("expiry_no_req", 32'(bus.eth_tx_req), 32'd0);
    send_byte(8'h3C, 1'b1);
    wait_flush("expiry", IDLE, IDLE + 1);
    release_req("expiry", 0, 1'b0);

    // Reset while filling, right as a write is on the bus.
    start_packet();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstfill_wren", 32'(bus.buf_wren), 32'd0);
    check("rstfill_waddr", 32'(bus.buf_waddr), 32'd0);
    check("rstfill_wdata", 32'(bus.buf_wdata), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_packet();
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_flush("post_rstfill", IDLE, IDLE);
    // Reset while requesting.
    rst_n = 1'b0;
    #1;
    check("rstreq_req", 32'(bus.eth_tx_req), 32'd0);
    check("rstreq_len", 32'(bus.eth_tx_len), 32'd0);
    check("rstreq_ovf", 32'(bus.overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_packet();
    send_byte(8'h9E, 1'b1);
    send_byte(8'hE9, 1'b1);
    wait_flush("post_rstreq", IDLE, IDLE);
    release_req("post_rstreq", 0, 1'b0);

    // Random packets with random inter-byte gaps below the timeout.
    for (int p = 0; p < 6; p++) begin
      start_packet();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        idle(int'($urandom_range(0, 6)));
        send_byte(8'($urandom), 1'b1);
      end
      wait_flush("rnd", IDLE, (n % 2 == 1) ? IDLE + 1 : IDLE);
      release_req("rnd", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
